// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle for bcd_display_scanner.
// Optional decimal-point lanes are present only when BCD_SCAN_DP_EN is defined.
//
// Signalling contract: there is no valid/ready handshake on this bundle.
//   - digits/lzb (and dp_in) are level inputs that are always valid.
//   - digits (and dp_in) are sampled once per scan frame.
//   - lzb is sampled on every clock.
//   - seg/an (and dp) are free-running registered outputs.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    lzb;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
`ifdef BCD_SCAN_DP_EN
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    dp;

  modport master (output digits, lzb, dp_in, input seg, an, dp);
  modport slave  (input digits, lzb, dp_in, output seg, an, dp);
`else
  modport master (output digits, lzb, input seg, an);
  modport slave  (input digits, lzb, output seg, an);
`endif
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment scanner for a chain of BCD counter digits.
//
// The scanner works as follows:
//   - All digits are snapshotted at the start of each frame, so a display never
//     mixes two counter values.
//   - One anode is strobed per PRESCALE-cycle slot.
//   - Leading-zero blanking is optional.
//
// Optional decimal points: define BCD_SCAN_DP_EN.
module bcd_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic                 clk,
  input logic                 reset,
  bcd_display_scanner_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (SEG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap;
  logic                    tick;
  logic                    frame_start;
  logic [NUM_DIGITS-1:0]   digit_nz;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    all_zero;
  logic [3:0]              cur_dig;
  logic [6:0]              cur_code;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_onehot;

  assign tick        = (presc == PRESC_LAST);
  assign frame_start = (presc == '0) && (idx == '0);

  // Logical active-high segment pattern, bit order g..a; codes 10..15 give a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // Slot prescaler and digit index; the index moves on the last cycle of each slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Frame snapshot: latch all digits once, at the first cycle of digit 0's slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap <= '0;
    end else if (frame_start) begin
      snap <= bus.digits;
    end
  end

`ifdef BCD_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] snap_dp;

  // Decimal points travel with the digit snapshot so they stay frame-consistent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_dp <= '0;
    end else if (frame_start) begin
      snap_dp <= bus.dp_in;
    end
  end

  // A lit decimal point makes its digit significant for blanking purposes.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nz
    assign digit_nz[g] = (snap[4*g +: 4] != 4'd0) | snap_dp[g];
  end
`else
  // Any nonzero code, including invalid 10..15, makes a digit significant.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nz
    assign digit_nz[g] = (snap[4*g +: 4] != 4'd0);
  end
`endif

  // Walk from the most significant digit down; a digit is a leading zero while
  // it and everything above it are zero. Digit 0 always stays lit.
  always_comb begin
    all_zero  = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & ~digit_nz[i];
      if (i != 0) blank_vec[i] = all_zero;
    end
  end

  // Select the digit currently being strobed.
  always_comb begin
    cur_dig   = snap[4*int'(idx) +: 4];
    cur_code  = decode(cur_dig);
    cur_blank = bus.lzb & blank_vec[idx];
    an_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  end

  // Registered display outputs, one cycle behind idx/snap, with polarity applied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.seg <= SEG_OFF;
      bus.an  <= AN_OFF;
    end else begin
      if (cur_blank) begin
        bus.seg <= SEG_OFF;
      end else begin
        bus.seg <= (SEG_ACTIVE_LOW != 0) ? ~cur_code : cur_code;
      end
      bus.an <= (SEG_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
    end
  end

`ifdef BCD_SCAN_DP_EN
  // Decimal point output follows the same latency and polarity as the segments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dp <= (SEG_ACTIVE_LOW != 0);
    end else begin
      bus.dp <= (SEG_ACTIVE_LOW != 0) ? ~snap_dp[idx] : snap_dp[idx];
    end
  end
`endif

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (NUM_DIGITS=4, PRESCALE=4, active-low).
// A cycle model pushes the expected {an,seg} for each edge into exp_q before the
// edge; the value is popped and compared on the following falling edge.
module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int PS = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [10:0] exp_q[$];

  // Reference model state
  int          m_presc;
  int          m_idx;
  logic [15:0] m_snap;

  logic [3:0] an_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Active-low seven-segment literals, bit order g..a
  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] SD   = 7'b0111111;
  localparam logic [6:0] SOFF = 7'h7F;

  bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS(ND),
    .PRESCALE(PS),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeout watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Active-low pattern for one BCD code
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = S0;
      4'd1:    seg_of = S1;
      4'd2:    seg_of = S2;
      4'd3:    seg_of = S3;
      4'd4:    seg_of = S4;
      4'd5:    seg_of = S5;
      4'd6:    seg_of = S6;
      4'd7:    seg_of = S7;
      4'd8:    seg_of = S8;
      4'd9:    seg_of = S9;
      default: seg_of = SD;
    endcase
  endfunction

  task automatic model_reset();
    m_presc = 0;
    m_idx   = 0;
    m_snap  = 16'h0000;
  endtask

  // One clock: predict, push, advance the model, clock, pop and compare.
  task automatic cycle();
    int          msd;
    logic [3:0]  d;
    logic [6:0]  s;
    logic [10:0] e;
    msd = 0;
    for (int j = 0; j < ND; j++) begin
      logic [3:0] dj;
      dj = m_snap[4*j +: 4];
      if (dj != 4'd0) msd = j;
    end
    d = m_snap[4*m_idx +: 4];
    s = (bus.lzb && (m_idx > msd)) ? SOFF : seg_of(d);
    exp_q.push_back({an_tab[m_idx], s});
    if (m_presc == 0 && m_idx == 0) m_snap = bus.digits;
    if (m_presc == PS - 1) begin
      m_presc = 0;
      m_idx   = (m_idx + 1) % ND;
    end else begin
      m_presc++;
    end
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("scan", {bus.an, bus.seg}, e);
`ifdef BCD_SCAN_DP_EN
    check("dp_off", {10'd0, bus.dp}, 11'd1);
`endif
  endtask

  // Run one full frame, checking a literal value at the end of each slot.
  task automatic run_frame_lit(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] sv[4];
    sv = '{s0, s1, s2, s3};
    for (int s = 0; s < ND; s++) begin
      repeat (PS) cycle();
      check($sformatf("%s_slot%0d", tag, s), {bus.an, bus.seg}, {an_tab[s], sv[s]});
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    bus.digits = 16'h1234;
    bus.lzb    = 1'b0;
`ifdef BCD_SCAN_DP_EN
    bus.dp_in  = '0;
`endif
    model_reset();

    // Reset values
    #12;
    check("reset_seg", {4'd0, bus.seg}, {4'd0, SOFF});
    check("reset_an", {7'd0, bus.an}, {7'd0, 4'hF});

    // Release; first edge shows '0' from the reset snapshot on digit 0
    @(negedge clk);
    reset = 1'b1;
    cycle();
    check("first_edge", {bus.an, bus.seg}, {4'b1110, S0});
    repeat (ND*PS - 1) cycle();

    // Second frame of 1234
    run_frame_lit("f2_1234", S4, S3, S2, S1);

    // Mid-frame change at idx=2: the rest of this frame still shows 2,1
    repeat (2*PS) cycle();
    bus.digits = 16'h5678;
    repeat (PS) cycle();
    check("mid_slot2", {bus.an, bus.seg}, {4'b1011, S2});
    repeat (PS) cycle();
    check("mid_slot3", {bus.an, bus.seg}, {4'b0111, S1});
    run_frame_lit("f_5678", S8, S7, S6, S5);

    // Leading-zero blanking
    bus.digits = 16'h0050;
    bus.lzb    = 1'b1;
    repeat (ND*PS) cycle();
    run_frame_lit("lzb_on", S0, S5, SOFF, SOFF);
    bus.lzb = 1'b0;
    run_frame_lit("lzb_off", S0, S5, S0, S0);

    // Invalid code counts as nonzero; all zeros keeps only digit 0 lit
    bus.digits = 16'h00A0;
    bus.lzb    = 1'b1;
    repeat (ND*PS) cycle();
    run_frame_lit("invalid", S0, SD, SOFF, SOFF);
    bus.digits = 16'h0000;
    repeat (ND*PS) cycle();
    run_frame_lit("all_zero", S0, SOFF, SOFF, SOFF);

    // Reset mid-scan at idx=3, presc=2
    bus.digits = 16'h1234;
    bus.lzb    = 1'b0;
    repeat (ND*PS) cycle();
    repeat (3*PS + 2) cycle();
    check("pre_reset_state", {bus.an, bus.seg}, {4'b0111, S1});
    #2;
    reset = 1'b0;
    #1;
    check("midreset_seg", {4'd0, bus.seg}, {4'd0, SOFF});
    check("midreset_an", {7'd0, bus.an}, {7'd0, 4'hF});
    model_reset();
    @(negedge clk);
    bus.digits = 16'h9876;
    reset      = 1'b1;
    cycle();
    check("restart_edge", {bus.an, bus.seg}, {4'b1110, S0});
    repeat (PS - 1) cycle();
    check("restart_slot0", {bus.an, bus.seg}, {4'b1110, S6});
    repeat (3*PS) cycle();
    run_frame_lit("f_9876", S6, S7, S8, S9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
